// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: counter states, BTB entry layout,
// counter init/alloc values and the saturating counter step.
package branch_predictor_pkg;

    localparam int PC_W      = 32;
    localparam int TAG_MAX_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // The tag field is sized for the smallest table; unused upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [PC_W-1:0]      target;
        bp_ctr_t              ctr;
    } bp_entry_t;

    localparam bp_ctr_t BP_CTR_INIT  = WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = WT;

    function automatic bp_ctr_t ctr_update(bp_ctr_t cur, logic taken);
        bp_ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = bp_ctr_t'(cur + 2'd1);
            end
        end else if (cur != SNT) begin
            nxt = bp_ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch, resolution and redirect signals between fetch/branch unit (master)
// and the predictor (slave).
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic            fetch_valid;
    logic            fetch_stall;
    logic [PC_W-1:0] fetch_pc;

    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;

    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic [PC_W-1:0] upd_pred_target;

    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output fetch_valid, fetch_stall, fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  mispredict, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_stall, fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_valid, pred_pc, pred_taken, pred_target,
        output mispredict, redirect_pc, branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one update port
// that applies the hit/allocate rules to the addressed entry.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output bp_entry_t            rd_entry,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_MAX_W-1:0] wr_tag,
    input  logic                 wr_taken,
    input  logic [PC_W-1:0]      wr_target
);

    logic                 valid_q  [ENTRIES];
    bp_ctr_t              ctr_q    [ENTRIES];
    logic [TAG_MAX_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]      target_q [ENTRIES];
    logic                 wr_hit;

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        rd_entry        = '0;
        rd_entry.valid  = valid_q[rd_idx];
        rd_entry.tag    = tag_q[rd_idx];
        rd_entry.target = target_q[rd_idx];
        rd_entry.ctr    = ctr_q[rd_idx];
    end

    // Only valid and counter need a reset; tag/target are qualified by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_CTR_INIT;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken);
            end else if (wr_taken) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= BP_CTR_ALLOC;
            end
        end
    end

    // A taken resolution writes tag and target whether it hit or allocated.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: registered BTB lookup, table training from
// resolved branches, registered mispredict/redirect and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0]     lk_idx;
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic [TAG_MAX_W-1:0] up_tag;
    bp_entry_t            lk_entry;
    logic                 lk_taken;
    logic [PC_W-1:0]      lk_target;
    logic                 mis_cond;

    logic                 pred_valid_q;
    logic [PC_W-1:0]      pred_pc_q;
    logic                 pred_taken_q;
    logic [PC_W-1:0]      pred_target_q;
    logic                 mispredict_q;
    logic [PC_W-1:0]      redirect_pc_q;
    logic [31:0]          branch_count_q;
    logic [31:0]          mispredict_count_q;

    assign lk_idx = bp.fetch_pc[IDX_W+1:2];
    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign lk_tag = {{IDX_W{1'b0}}, bp.fetch_pc[31 -: TAG_W]};
    assign up_tag = {{IDX_W{1'b0}}, bp.upd_pc[31 -: TAG_W]};

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (lk_idx),
        .rd_entry  (lk_entry),
        .wr_en     (bp.upd_valid),
        .wr_idx    (up_idx),
        .wr_tag    (up_tag),
        .wr_taken  (bp.upd_taken),
        .wr_target (bp.upd_target)
    );

    // Lookup reads the pre-update table contents: no write-to-read bypass.
    always_comb begin
        lk_taken  = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
        lk_target = lk_taken ? lk_entry.target : bp.fetch_pc + 32'd4;
    end

    assign mis_cond = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (!bp.fetch_stall) begin
            pred_valid_q <= bp.fetch_valid;
            if (bp.fetch_valid) begin
                pred_pc_q     <= bp.fetch_pc;
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_target;
            end
        end
    end

    // redirect_pc keeps the last correction until the next mispredict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mispredict_q <= mis_cond;
            if (mis_cond) begin
                redirect_pc_q <= bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bp.upd_valid && (branch_count_q != '1)) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (mis_cond && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign bp.pred_valid       = pred_valid_q;
    assign bp.pred_pc          = pred_pc_q;
    assign bp.pred_taken       = pred_taken_q;
    assign bp.pred_target      = pred_target_q;
    assign bp.mispredict       = mispredict_q;
    assign bp.redirect_pc      = redirect_pc_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random
// traffic, checked every cycle against an array-based reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    logic clk;
    logic rst;
    int   num_checks = 0;
    int   num_fail   = 0;
    int   cycle      = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t m_out;

    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];

    branch_predictor_if bp_if();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) & (ENTRIES - 1));
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("pred_valid", 32'(bp_if.pred_valid), 32'(e.pv));
        if (e.pv) begin
            checkField("pred_pc", bp_if.pred_pc, e.ppc);
            checkField("pred_taken", 32'(bp_if.pred_taken), 32'(e.pt));
            checkField("pred_target", bp_if.pred_target, e.ptgt);
        end
        checkField("mispredict", 32'(bp_if.mispredict), 32'(e.mis));
        checkField("redirect_pc", bp_if.redirect_pc, e.rpc);
        checkField("branch_count", bp_if.branch_count, e.bc);
        checkField("mispredict_count", bp_if.mispredict_count, e.mc);
    endtask

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_out.pv   = 1'b0;
        m_out.ppc  = '0;
        m_out.pt   = 1'b0;
        m_out.ptgt = '0;
        m_out.mis  = 1'b0;
        m_out.rpc  = '0;
        m_out.bc   = '0;
        m_out.mc   = '0;
    endtask

    task automatic driveIdle();
        bp_if.fetch_valid     = 1'b0;
        bp_if.fetch_stall     = 1'b0;
        bp_if.fetch_pc        = '0;
        bp_if.upd_valid       = 1'b0;
        bp_if.upd_pc          = '0;
        bp_if.upd_taken       = 1'b0;
        bp_if.upd_target      = '0;
        bp_if.upd_pred_taken  = 1'b0;
        bp_if.upd_pred_target = '0;
    endtask

    // Drive one cycle of inputs at a negedge, record what the next edge must produce.
    task automatic applyStimulus(input logic fv, input logic fs, input logic [31:0] fpc,
                                 input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
        int li;
        int ui;
        bit lhit;
        bit uhit;
        bit mis;
        bp_if.fetch_valid     = fv;
        bp_if.fetch_stall     = fs;
        bp_if.fetch_pc        = fpc;
        bp_if.upd_valid       = uv;
        bp_if.upd_pc          = upc;
        bp_if.upd_taken       = ut;
        bp_if.upd_target      = utgt;
        bp_if.upd_pred_taken  = upt;
        bp_if.upd_pred_target = uptgt;

        li   = idx_of(fpc);
        lhit = m_valid[li] && (m_tag[li] == tag_of(fpc));
        if (fv && !fs) begin
            m_out.pv   = 1'b1;
            m_out.ppc  = fpc;
            m_out.pt   = lhit && (m_ctr[li] >= 2);
            m_out.ptgt = m_out.pt ? m_target[li] : fpc + 32'd4;
        end else if (!fs) begin
            m_out.pv = 1'b0;
        end

        mis = uv && ((ut != upt) || (ut && (utgt != uptgt)));
        m_out.mis = mis;
        if (mis) m_out.rpc = ut ? utgt : upc + 32'd4;
        if (uv && (m_out.bc != 32'hFFFF_FFFF)) m_out.bc = m_out.bc + 32'd1;
        if (mis && (m_out.mc != 32'hFFFF_FFFF)) m_out.mc = m_out.mc + 32'd1;
        exp_q.push_back(m_out);

        if (uv) begin
            ui   = idx_of(upc);
            uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
            if (uhit) begin
                if (ut) begin
                    m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_target[ui] = utgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end else if (ut) begin
                m_valid[ui]  = 1'b1;
                m_tag[ui]    = tag_of(upc);
                m_target[ui] = utgt;
                m_ctr[ui]    = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(1'b1, 1'b0, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, pc, t, tgt, pt, ptgt);
    endtask

    task automatic doReset();
        rst = 1'b1;
        driveIdle();
        exp_q.delete();
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one expected record per clock edge while out of reset.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!rst) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fail++;
                    $display("[TB] FAIL scoreboard_underrun at cycle %0d: got empty queue, expected a record", cycle);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput(mon_e);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        rt;
        rst = 1'b1;
        driveIdle();
        modelReset();
        #1;
        checkField("reset_pred_valid", 32'(bp_if.pred_valid), 32'd0);
        checkField("reset_branch_count", bp_if.branch_count, 32'd0);
        doReset();

        lookup(32'h100);
        update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        lookup(32'h100);
        update(32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        lookup(32'h100);

        update(32'h140, 1'b1, 32'h300, 1'b1, 32'h300);
        lookup(32'h100);
        lookup(32'h140);

        applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h400, 1'b0, 32'h104);
        lookup(32'h100);

        lookup(32'h140);
        repeat (3) applyStimulus(1'b1, 1'b1, 32'h999, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        lookup(32'hFFFF_FFFC);
        update(32'h200, 1'b1, 32'h500, 1'b0, 32'h500);
        update(32'h200, 1'b1, 32'h500, 1'b1, 32'h600);
        update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h700);
        update(32'h200, 1'b1, 32'h500, 1'b1, 32'h500);

        // Reset while a mispredict pulse and a prediction are both live.
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 32'h300, 1'b1, 32'h800, 1'b0, 32'h304);
        driveIdle();
        checkField("pre_reset_mispredict", 32'(bp_if.mispredict), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkField("async_rst_mispredict", 32'(bp_if.mispredict), 32'd0);
        checkField("async_rst_pred_valid", 32'(bp_if.pred_valid), 32'd0);
        checkField("async_rst_branch_count", bp_if.branch_count, 32'd0);
        checkField("async_rst_mispredict_count", bp_if.mispredict_count, 32'd0);
        checkField("async_rst_redirect_pc", bp_if.redirect_pc, 32'd0);
        exp_q.delete();
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lookup(32'h100);
        lookup(32'h140);
        lookup(32'h300);

        for (int i = 0; i < 600; i++) begin
            rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            rtgt = 32'h1000 + ($urandom_range(0, 3) << 4);
            rt   = ($urandom_range(0, 1) == 1);
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
                          ($urandom_range(0, 1) == 1), rpc, rt, rtgt,
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1) ? rtgt : 32'h1000 + ($urandom_range(0, 3) << 4));
        end

        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        checkField("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
